// File: rtl/demux_pkg.sv
// Shared definitions for the packet-aware 1:2 stream demultiplexer:
// FSM state encoding and the default beat width.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTE0 = 2'd1,
    ST_ROUTE1 = 2'd2
  } state_e;

endpackage

// File: rtl/one_two_demux_if.sv
// Stream bundle for one_two_demux: one valid/ready input plus the two
// steered outputs. The producer/consumer side uses master, the demux uses slave.
interface one_two_demux_if #(
  parameter int WIDTH = demux_pkg::DEFAULT_WIDTH
);
  logic             s1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;

  modport master (
    output s1, in_valid, in_data, in_last, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last,
           out1_valid, out1_data, out1_last
  );

  modport slave (
    input  s1, in_valid, in_data, in_last, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last,
           out1_valid, out1_data, out1_last
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry output register slice: loads a beat, drains on ready, and holds
// its contents stable while the consumer stalls.
module demux_slot #(
  parameter int WIDTH = demux_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_can_load
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      // NOTE: the payload register is reset as well so the outputs read zero
      // after reset and no stale beat from before reset can resurface.
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      // A load wins over a simultaneous drain: the slot simply stays full.
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/one_two_demux.sv
// Packet-aware 1:2 demultiplexer: binds each packet to the output chosen by
// s1 on its first beat and steers all its beats through per-output slots.
module one_two_demux
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  one_two_demux_if.slave bus
);

  state_e r_state;
  state_e w_state_next;

  logic w_dest;
  logic w_accept;
  logic w_load0;
  logic w_load1;
  logic w_in_ready;
  logic w_can_load0;
  logic w_can_load1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_accept && !bus.in_last)
          w_state_next = bus.s1 ? ST_ROUTE1 : ST_ROUTE0;
      ST_ROUTE0, ST_ROUTE1:
        if (w_accept && bus.in_last)
          w_state_next = ST_IDLE;
      default:
        w_state_next = ST_IDLE;
    endcase
  end

  // Destination comes from s1 only while no packet is open; in_ready never
  // depends on in_valid, so accept is the only term that does.
  always_comb begin
    w_dest     = (r_state == ST_ROUTE1) || ((r_state == ST_IDLE) && bus.s1);
    w_in_ready = w_dest ? w_can_load1 : w_can_load0;
    w_accept   = bus.in_valid && w_in_ready;
    w_load0    = w_accept && !w_dest;
    w_load1    = w_accept && w_dest;
  end

  assign bus.in_ready = w_in_ready;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load0),
    .i_data     (bus.in_data),
    .i_last     (bus.in_last),
    .i_ready    (bus.out0_ready),
    .o_valid    (bus.out0_valid),
    .o_data     (bus.out0_data),
    .o_last     (bus.out0_last),
    .o_can_load (w_can_load0)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load1),
    .i_data     (bus.in_data),
    .i_last     (bus.in_last),
    .i_ready    (bus.out1_ready),
    .o_valid    (bus.out1_valid),
    .o_data     (bus.out1_data),
    .o_last     (bus.out1_last),
    .o_can_load (w_can_load1)
  );

endmodule
